serial_frame_rx: RTL and testbench

- Synchronous serial frame receiver built from enable-gated flops. It is the receiving end of the team's single-wire framed serial link.
- The transmitter drives one bit per enabled clock:
  - start bit (0)
  - DATA_WIDTH data bits, LSB first
  - optional even-parity bit
  - stop bit (1)
- The block deserializes the frame, checks parity and stop bit, and presents the parallel word with a one-cycle valid pulse.

---
 rtl/serial_frame_rx.sv | 128 ++++++++++++
 tb/tb_serial_frame_rx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Receiving end of the single-wire framed serial link. A frame is a start
//   bit (0), DATA_WIDTH data bits LSB first, an optional even-parity bit and
//   a stop bit (1). One bit is sampled on each clock edge where en is high.
//   A correctly framed word is presented on data_out together with a
//   one-cycle valid_out pulse.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high, overrides en/rx_in
//   en         in   bit-sample enable; FSM, counter and shift register hold when low
//   rx_in      in   serial line, idles high
//   data_out   out  last correctly framed word, held until the next good frame
//   valid_out  out  one-cycle pulse when data_out is updated
//   parity_err out  one-cycle pulse with valid_out when parity mismatched
//   frame_err  out  one-cycle pulse when the stop bit sampled 0
//   busy       out  high whenever the receiver is not idle

module serial_frame_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          USE_PARITY = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  perr_q, perr_d;        // mismatch captured in PARITY
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_out_q, perr_out_d;
    logic                  ferr_q, ferr_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        data_d     = data_q;
        // Status pulses default low every cycle so they last one clock even
        // when en is low on the following edge.
        valid_d    = 1'b0;
        perr_out_d = 1'b0;
        ferr_d     = 1'b0;

        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_in) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        perr_d  = 1'b0;
                    end
                end
                S_DATA: begin
                    // LSB arrives first, so shifting right leaves it at bit 0
                    // once all DATA_WIDTH bits are in.
                    shift_d = {rx_in, shift_q[DATA_WIDTH-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = USE_PARITY ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    perr_d  = rx_in ^ (^shift_q);
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (rx_in) begin
                        data_d     = shift_q;
                        valid_d    = 1'b1;
                        perr_out_d = perr_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_q     <= ferr_d;
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx
//   Directed bench for serial_frame_rx (DATA_WIDTH=8, USE_PARITY=1).
//   Inputs change on the falling edge; outputs are checked #1 after the
//   rising edge that produced them.

module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int vcount = 0;   // number of cycles valid_out was seen high

    serial_frame_rx #(.DATA_WIDTH(8), .USE_PARITY(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (valid_out) vcount++;

    // One clock: apply inputs at the falling edge, return #1 after the rise.
    task automatic step(input logic r, input logic e, input logic b);
        @(negedge clk);
        rst = r; en = e; rx_in = b;
        @(posedge clk);
        #1;
    endtask

    // Start, data LSB first, parity, stop; returns just after the stop edge.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, d[i]);
        step(1'b0, 1'b1, p);
        step(1'b0, 1'b1, s);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        tests++;
        if ({data_out, valid_out, parity_err, frame_err, busy} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 000",
                     {data_out, valid_out, parity_err, frame_err, busy});
        end
    endtask

    task automatic test_good_frame();
        int v0;
        v0 = vcount;
        step(1'b0, 1'b1, 1'b0);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL good_busy_after_start: got %b expected 1", busy); end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, i == 0 || i == 2 || i == 5 || i == 7);
        step(1'b0, 1'b1, 1'b0);
        tests++;
        if (valid_out !== 1'b0) begin fails++; $display("FAIL good_no_early_valid: got %b expected 0", valid_out); end
        step(1'b0, 1'b1, 1'b1);
        tests++;
        if ({valid_out, parity_err, frame_err, busy} !== 4'b1000 || data_out !== 8'hA5) begin
            fails++;
            $display("FAIL good_frame: got v%b p%b f%b b%b d=%h expected v1 p0 f0 b0 d=a5",
                     valid_out, parity_err, frame_err, busy, data_out);
        end
        step(1'b0, 1'b1, 1'b1);
        tests++;
        if (valid_out !== 1'b0 || vcount - v0 !== 1) begin
            fails++;
            $display("FAIL good_pulse_width: got v%b pulses=%0d expected v0 pulses=1", valid_out, vcount - v0);
        end
    endtask

    task automatic test_frame_err();
        int v0;
        v0 = vcount;
        send_frame(8'h3C, 1'b0, 1'b0);
        tests++;
        if ({frame_err, valid_out, parity_err, busy} !== 4'b1000 || data_out !== 8'hA5) begin
            fails++;
            $display("FAIL frame_err: got f%b v%b p%b b%b d=%h expected f1 v0 p0 b0 d=a5",
                     frame_err, valid_out, parity_err, busy, data_out);
        end
        step(1'b0, 1'b1, 1'b1);
        tests++;
        if (frame_err !== 1'b0 || vcount != v0) begin
            fails++;
            $display("FAIL frame_err_pulse: got f%b pulses=%0d expected f0 pulses=0", frame_err, vcount - v0);
        end
    endtask

    task automatic test_parity_err();
        send_frame(8'h01, 1'b0, 1'b1);
        tests++;
        if ({valid_out, parity_err, frame_err} !== 3'b110 || data_out !== 8'h01) begin
            fails++;
            $display("FAIL parity_err: got v%b p%b f%b d=%h expected v1 p1 f0 d=01",
                     valid_out, parity_err, frame_err, data_out);
        end
        // Pulse must drop even though en is low on the next edge.
        step(1'b0, 1'b0, 1'b1);
        tests++;
        if (parity_err !== 1'b0 || valid_out !== 1'b0) begin
            fails++;
            $display("FAIL parity_pulse_en_low: got p%b v%b expected p0 v0", parity_err, valid_out);
        end
    endtask

    task automatic test_en_stretch();
        logic [7:0] d;
        int v0;
        d  = 8'h5A;
        v0 = vcount;
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, d[i]);
            // Line driven to the wrong value while disabled; must be ignored.
            if (i == 3) for (int k = 0; k < 3; k++) step(1'b0, 1'b0, ~d[i]);
        end
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 1'b0);
        tests++;
        if (vcount != v0 || busy !== 1'b1 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL stretch_early: got pulses=%0d busy=%b f%b expected 0 1 0", vcount - v0, busy, frame_err);
        end
        step(1'b0, 1'b1, 1'b1);
        tests++;
        if ({valid_out, parity_err, frame_err} !== 3'b100 || data_out !== 8'h5A) begin
            fails++;
            $display("FAIL stretch_frame: got v%b p%b f%b d=%h expected v1 p0 f0 d=5a",
                     valid_out, parity_err, frame_err, data_out);
        end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);
        tests++;
        if (vcount - v0 !== 1) begin
            fails++;
            $display("FAIL stretch_pulse_count: got %0d expected 1", vcount - v0);
        end
    endtask

    task automatic test_reset_mid();
        int v0;
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
        v0 = vcount;
        step(1'b1, 1'b1, 1'b0);
        tests++;
        if ({data_out, valid_out, parity_err, frame_err, busy} !== 12'h000) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %h expected 000",
                     {data_out, valid_out, parity_err, frame_err, busy});
        end
        send_frame(8'hC3, 1'b0, 1'b1);
        tests++;
        if ({valid_out, parity_err, frame_err} !== 3'b100 || data_out !== 8'hC3 || vcount != v0) begin
            fails++;
            $display("FAIL reset_mid_next_frame: got v%b p%b f%b d=%h prior_pulses=%0d expected v1 p0 f0 d=c3 0",
                     valid_out, parity_err, frame_err, data_out, vcount - v0);
        end
        step(1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if ({busy, valid_out, frame_err} !== 3'b000) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL idle_line: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b0, 1'b1);
        tests++;
        if (valid_out !== 1'b1 || data_out !== 8'h11) begin
            fails++;
            $display("FAIL b2b_first: got v%b d=%h expected v1 d=11", valid_out, data_out);
        end
        send_frame(8'h22, 1'b0, 1'b1);
        tests++;
        if ({valid_out, parity_err, frame_err} !== 3'b100 || data_out !== 8'h22) begin
            fails++;
            $display("FAIL b2b_second: got v%b p%b f%b d=%h expected v1 p0 f0 d=22",
                     valid_out, parity_err, frame_err, data_out);
        end
        step(1'b0, 1'b1, 1'b1);
        tests++;
        if (busy !== 1'b0 || valid_out !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle_after: got b%b v%b expected b0 v0", busy, valid_out);
        end
    endtask

    initial begin
        test_reset();
        step(1'b0, 1'b1, 1'b1);
        test_good_frame();
        test_frame_err();
        test_parity_err();
        test_en_stretch();
        test_reset_mid();
        test_idle();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
